// File: rtl/sha256_ctrl_pkg.sv
// Shared definitions for the multi-block SHA-256 control sequencer:
// state encoding, W byte-source codes, phase lengths and block-count helper.
package sha256_ctrl_pkg;

  localparam int unsigned DEF_OUTPUT_LENGTH      = 8;
  localparam int unsigned DEF_MAX_MESSAGE_LENGTH = 247;
  localparam int unsigned DEF_NUMBER_OF_KS       = 64;
  localparam int unsigned DEF_NUMBER_OF_HS       = 8;

  localparam int unsigned PHASE_W         = 7;
  localparam int unsigned BLOCK_BYTES     = 64;
  localparam int unsigned BYTE_IDX_W      = 6;
  localparam int unsigned LEN_FIELD_BYTES = 8;
  localparam int unsigned LEN_FIELD_START = BLOCK_BYTES - LEN_FIELD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HLOAD  = 3'd1,
    ST_MLOAD  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    SEL_MSG  = 2'd0,
    SEL_PAD  = 2'd1,
    SEL_ZERO = 2'd2,
    SEL_LEN  = 2'd3
  } wsel_e;

  // Blocks needed for L message bytes plus the 0x80 marker and 8-byte length field
  function automatic int unsigned num_blocks(input int unsigned len);
    return (len + LEN_FIELD_BYTES) / BLOCK_BYTES + 1;
  endfunction

endpackage

// File: rtl/sha256_multiblock_ctrl_if.sv
// Memory-port and datapath-strobe bundle between the SHA-256 sequencer and its environment.
interface sha256_multiblock_ctrl_if
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W  = $clog2(DEF_MAX_MESSAGE_LENGTH) + 1,
  parameter int unsigned MSG_AW = $clog2(DEF_MAX_MESSAGE_LENGTH),
  parameter int unsigned K_AW   = $clog2(DEF_NUMBER_OF_KS),
  parameter int unsigned H_AW   = $clog2(DEF_NUMBER_OF_HS),
  parameter int unsigned DOM_AW = $clog2(DEF_OUTPUT_LENGTH)
);

  logic              xxx__dut__go;
  logic [LEN_W-1:0]  xxx__dut__msg_length;
  logic [MSG_AW-1:0] dut__msg__address;
  logic              dut__msg__enable;
  logic              dut__msg__write;
  logic [K_AW-1:0]   dut__kmem__address;
  logic              dut__kmem__enable;
  logic              dut__kmem__write;
  logic [H_AW-1:0]   dut__hmem__address;
  logic              dut__hmem__enable;
  logic              dut__hmem__write;
  logic [DOM_AW-1:0] dut__dom__address;
  logic              dut__dom__enable;
  logic              dut__dom__write;
  logic              dut__xxx__finish;
  logic              busy;
  logic              H_read;
  logic              W_load;
  logic [1:0]        W_byte_sel;
  logic              H_iterate;
  logic              H_update;

  modport master (
    input  xxx__dut__go, xxx__dut__msg_length,
    output dut__msg__address, dut__msg__enable, dut__msg__write,
           dut__kmem__address, dut__kmem__enable, dut__kmem__write,
           dut__hmem__address, dut__hmem__enable, dut__hmem__write,
           dut__dom__address, dut__dom__enable, dut__dom__write,
           dut__xxx__finish, busy, H_read, W_load, W_byte_sel, H_iterate, H_update
  );

  modport slave (
    output xxx__dut__go, xxx__dut__msg_length,
    input  dut__msg__address, dut__msg__enable, dut__msg__write,
           dut__kmem__address, dut__kmem__enable, dut__kmem__write,
           dut__hmem__address, dut__hmem__enable, dut__hmem__write,
           dut__dom__address, dut__dom__enable, dut__dom__write,
           dut__xxx__finish, busy, H_read, W_load, W_byte_sel, H_iterate, H_update
  );

endinterface

// File: rtl/sha256_pad_classifier.sv
// Classifies one W byte position as message data, 0x80 marker, zero fill or length byte.
module sha256_pad_classifier
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned GW = 9,
  parameter int unsigned LW = 9,
  parameter int unsigned BW = 3,
  parameter int unsigned PW = 7
) (
  input  logic [GW-1:0] i_g,
  input  logic [LW-1:0] i_len,
  input  logic [BW-1:0] i_blk,
  input  logic [BW-1:0] i_nblk,
  input  logic [PW-1:0] i_phase,
  output logic          o_msg_en_c,
  output wsel_e         o_sel_c
);

  always_comb begin
    o_msg_en_c = 1'b0;
    o_sel_c    = SEL_ZERO;
    if (32'(i_g) < 32'(i_len)) begin
      o_msg_en_c = 1'b1;
      o_sel_c    = SEL_MSG;
    end else if (32'(i_g) == 32'(i_len)) begin
      o_sel_c = SEL_PAD;
    end else if ((i_blk == i_nblk - BW'(1)) && (32'(i_phase) >= LEN_FIELD_START)) begin
      o_sel_c = SEL_LEN;
    end
  end

endmodule

// File: rtl/sha256_multiblock_ctrl.sv
// Multi-block SHA-256 control sequencer: H load, per-block W load/rounds/H update, digest write.
module sha256_multiblock_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned OUTPUT_LENGTH      = DEF_OUTPUT_LENGTH,
  parameter int unsigned MAX_MESSAGE_LENGTH = DEF_MAX_MESSAGE_LENGTH,
  parameter int unsigned NUMBER_OF_KS       = DEF_NUMBER_OF_KS,
  parameter int unsigned NUMBER_OF_HS       = DEF_NUMBER_OF_HS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  sha256_multiblock_ctrl_if.master bus
);

  localparam int unsigned LEN_W      = $clog2(MAX_MESSAGE_LENGTH) + 1;
  localparam int unsigned MSG_AW     = $clog2(MAX_MESSAGE_LENGTH);
  localparam int unsigned K_AW       = $clog2(NUMBER_OF_KS);
  localparam int unsigned H_AW       = $clog2(NUMBER_OF_HS);
  localparam int unsigned DOM_AW     = $clog2(OUTPUT_LENGTH);
  localparam int unsigned MAX_BLOCKS = (MAX_MESSAGE_LENGTH + LEN_FIELD_BYTES) / BLOCK_BYTES + 1;
  localparam int unsigned BLK_W      = $clog2(MAX_BLOCKS) + 1;
  localparam int unsigned G_W        = BLK_W + BYTE_IDX_W;

  localparam logic [PHASE_W-1:0] H_LAST   = PHASE_W'(NUMBER_OF_HS - 1);
  localparam logic [PHASE_W-1:0] MSG_LAST = PHASE_W'(BLOCK_BYTES - 1);
  localparam logic [PHASE_W-1:0] K_LAST   = PHASE_W'(NUMBER_OF_KS - 1);
  localparam logic [PHASE_W-1:0] D_LAST   = PHASE_W'(OUTPUT_LENGTH - 1);

  state_e             r_state, w_state_nxt;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  logic [BLK_W-1:0]   r_blk, w_blk_nxt;
  logic               r_go;
  logic [LEN_W-1:0]   r_len_s, r_len;
  logic [BLK_W-1:0]   r_nblk;
  logic               w_last_blk;

  logic [G_W-1:0]     w_g_nxt;
  logic               w_cls_msg_en;
  wsel_e              w_cls_sel;

  logic               w_mload_nxt, w_msg_en_nxt, w_kmem_en_nxt, w_hmem_en_nxt, w_dom_en_nxt;
  logic [MSG_AW-1:0]  w_msg_addr_nxt;
  logic [K_AW-1:0]    w_kmem_addr_nxt;
  logic [H_AW-1:0]    w_hmem_addr_nxt;
  logic [DOM_AW-1:0]  w_dom_addr_nxt;
  wsel_e              w_sel_nxt;
  logic               w_h_update_nxt, w_finish_nxt, w_busy_nxt;

  logic               r_msg_en, r_kmem_en, r_hmem_en, r_dom_en;
  logic [MSG_AW-1:0]  r_msg_addr;
  logic [K_AW-1:0]    r_kmem_addr;
  logic [H_AW-1:0]    r_hmem_addr;
  logic [DOM_AW-1:0]  r_dom_addr;
  logic               r_h_update, r_finish, r_busy;
  logic               r_mload;
  wsel_e              r_sel_p, r_w_sel;
  logic               r_w_load, r_h_read, r_h_iterate;

  // Input sampling; length and block count frozen when a run starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_go    <= 1'b0;
      r_len_s <= '0;
      r_len   <= '0;
      r_nblk  <= '0;
    end else begin
      r_go    <= bus.xxx__dut__go;
      r_len_s <= (32'(bus.xxx__dut__msg_length) > MAX_MESSAGE_LENGTH) ?
                 LEN_W'(MAX_MESSAGE_LENGTH) : bus.xxx__dut__msg_length;
      if (r_state == ST_IDLE && r_go) begin
        r_len  <= r_len_s;
        r_nblk <= BLK_W'(num_blocks(32'(r_len_s)));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_blk   <= w_blk_nxt;
    end
  end

  assign w_last_blk = (r_blk == r_nblk - BLK_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + PHASE_W'(1);
    w_blk_nxt   = r_blk;
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = '0;
        if (r_go) w_state_nxt = ST_HLOAD;
      end
      ST_HLOAD: if (r_phase == H_LAST) begin
        w_state_nxt = ST_MLOAD;
        w_phase_nxt = '0;
        w_blk_nxt   = '0;
      end
      ST_MLOAD: if (r_phase == MSG_LAST) begin
        w_state_nxt = ST_ROUND;
        w_phase_nxt = '0;
      end
      ST_ROUND: if (r_phase == K_LAST) begin
        w_state_nxt = ST_UPDATE;
        w_phase_nxt = '0;
      end
      ST_UPDATE: if (r_phase == H_LAST) begin
        w_phase_nxt = '0;
        if (w_last_blk) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_MLOAD;
          w_blk_nxt   = r_blk + BLK_W'(1);
        end
      end
      ST_WRITE: if (r_phase == D_LAST) begin
        w_state_nxt = ST_DONE;
        w_phase_nxt = '0;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  assign w_g_nxt = {w_blk_nxt, w_phase_nxt[BYTE_IDX_W-1:0]};

  sha256_pad_classifier #(
    .GW (G_W),
    .LW (LEN_W),
    .BW (BLK_W),
    .PW (PHASE_W)
  ) u_pad_classifier (
    .i_g        (w_g_nxt),
    .i_len      (r_len),
    .i_blk      (w_blk_nxt),
    .i_nblk     (r_nblk),
    .i_phase    (w_phase_nxt),
    .o_msg_en_c (w_cls_msg_en),
    .o_sel_c    (w_cls_sel)
  );

  // Output values for the upcoming state, registered so they align with it
  always_comb begin
    w_mload_nxt     = 1'b0;
    w_msg_en_nxt    = 1'b0;
    w_msg_addr_nxt  = '0;
    w_sel_nxt       = SEL_MSG;
    w_kmem_en_nxt   = 1'b0;
    w_kmem_addr_nxt = '0;
    w_hmem_en_nxt   = 1'b0;
    w_hmem_addr_nxt = '0;
    w_dom_en_nxt    = 1'b0;
    w_dom_addr_nxt  = '0;
    w_h_update_nxt  = (w_state_nxt == ST_UPDATE);
    w_finish_nxt    = (w_state_nxt == ST_DONE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    if (w_state_nxt == ST_MLOAD) begin
      w_mload_nxt  = 1'b1;
      w_msg_en_nxt = w_cls_msg_en;
      w_sel_nxt    = w_cls_sel;
      if (w_cls_msg_en) w_msg_addr_nxt = MSG_AW'(w_g_nxt);
    end
    if (w_state_nxt == ST_ROUND) begin
      w_kmem_en_nxt   = 1'b1;
      w_kmem_addr_nxt = K_AW'(w_phase_nxt);
    end
    if (w_state_nxt == ST_HLOAD) begin
      w_hmem_en_nxt   = 1'b1;
      w_hmem_addr_nxt = H_AW'(w_phase_nxt);
    end
    if (w_state_nxt == ST_WRITE) begin
      w_dom_en_nxt   = 1'b1;
      w_dom_addr_nxt = DOM_AW'(w_phase_nxt);
    end
  end

  // Registered outputs plus one-cycle read-latency delay for the data-valid strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_en    <= 1'b0;
      r_msg_addr  <= '0;
      r_kmem_en   <= 1'b0;
      r_kmem_addr <= '0;
      r_hmem_en   <= 1'b0;
      r_hmem_addr <= '0;
      r_dom_en    <= 1'b0;
      r_dom_addr  <= '0;
      r_h_update  <= 1'b0;
      r_finish    <= 1'b0;
      r_busy      <= 1'b0;
      r_mload     <= 1'b0;
      r_sel_p     <= SEL_MSG;
      r_w_load    <= 1'b0;
      r_w_sel     <= SEL_MSG;
      r_h_read    <= 1'b0;
      r_h_iterate <= 1'b0;
    end else begin
      r_msg_en    <= w_msg_en_nxt;
      r_msg_addr  <= w_msg_addr_nxt;
      r_kmem_en   <= w_kmem_en_nxt;
      r_kmem_addr <= w_kmem_addr_nxt;
      r_hmem_en   <= w_hmem_en_nxt;
      r_hmem_addr <= w_hmem_addr_nxt;
      r_dom_en    <= w_dom_en_nxt;
      r_dom_addr  <= w_dom_addr_nxt;
      r_h_update  <= w_h_update_nxt;
      r_finish    <= w_finish_nxt;
      r_busy      <= w_busy_nxt;
      r_mload     <= w_mload_nxt;
      r_sel_p     <= w_sel_nxt;
      r_w_load    <= r_mload;
      r_w_sel     <= r_sel_p;
      r_h_read    <= r_hmem_en;
      r_h_iterate <= r_kmem_en;
    end
  end

  assign bus.dut__msg__address  = r_msg_addr;
  assign bus.dut__msg__enable   = r_msg_en;
  assign bus.dut__msg__write    = 1'b0;
  assign bus.dut__kmem__address = r_kmem_addr;
  assign bus.dut__kmem__enable  = r_kmem_en;
  assign bus.dut__kmem__write   = 1'b0;
  assign bus.dut__hmem__address = r_hmem_addr;
  assign bus.dut__hmem__enable  = r_hmem_en;
  assign bus.dut__hmem__write   = 1'b0;
  assign bus.dut__dom__address  = r_dom_addr;
  assign bus.dut__dom__enable   = r_dom_en;
  assign bus.dut__dom__write    = r_dom_en;
  assign bus.dut__xxx__finish   = r_finish;
  assign bus.busy               = r_busy;
  assign bus.H_read             = r_h_read;
  assign bus.W_load             = r_w_load;
  assign bus.W_byte_sel         = r_w_sel;
  assign bus.H_iterate          = r_h_iterate;
  assign bus.H_update           = r_h_update;

endmodule

// File: tb/tb_sha256_multiblock_ctrl.sv
// Randomized bench for the SHA-256 sequencer, checked against a padded-message reference model.
module tb_sha256_multiblock_ctrl;

  localparam int unsigned MAXL = 247;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  sha256_multiblock_ctrl_if bus ();

  sha256_multiblock_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned nonzero_outs();
    return int'(|bus.dut__msg__address) + int'(bus.dut__msg__enable) + int'(bus.dut__msg__write)
         + int'(|bus.dut__kmem__address) + int'(bus.dut__kmem__enable) + int'(bus.dut__kmem__write)
         + int'(|bus.dut__hmem__address) + int'(bus.dut__hmem__enable) + int'(bus.dut__hmem__write)
         + int'(|bus.dut__dom__address) + int'(bus.dut__dom__enable) + int'(bus.dut__dom__write)
         + int'(bus.dut__xxx__finish) + int'(bus.busy) + int'(bus.H_read) + int'(bus.W_load)
         + int'(|bus.W_byte_sel) + int'(bus.H_iterate) + int'(bus.H_update);
  endfunction

  // Byte class of position p in the padded message of L bytes spread over total bytes
  function automatic int unsigned pad_class(input int unsigned p, input int unsigned l,
                                            input int unsigned total);
    if (p < l)          return 0;
    if (p == l)         return 1;
    if (p >= total - 8) return 3;
    return 2;
  endfunction

  task automatic run_msg(input int unsigned len, input bit poke_go);
    int unsigned lsat, nblk, total, k, fin_cyc, busy_after;
    int unsigned n_fin, n_busy, n_hread, n_iter, n_upd, lag_err, wr_err, post;
    int unsigned q_addr[$], q_sel[$], q_h[$], q_k[$], q_d[$];
    bit          prev_h, prev_k, prev_m, seen_fin;
    string       p;

    lsat  = (len > MAXL) ? MAXL : len;
    nblk  = (lsat + 9 + 63) / 64;
    total = 64 * nblk;
    p     = $sformatf("L%0d_", len);
    {fin_cyc, n_fin, n_busy, n_hread, n_iter, n_upd, lag_err, wr_err, post} = '0;
    busy_after = 1;
    {prev_h, prev_k, prev_m, seen_fin} = '0;

    @(negedge clk);
    bus.xxx__dut__go         = 1'b1;
    bus.xxx__dut__msg_length = 9'(len);
    k = cyc + 1;
    @(negedge clk);
    bus.xxx__dut__go = 1'b0;

    for (int t = 0; t < 900 && post < 4; t++) begin
      @(negedge clk);
      if (seen_fin) begin
        post++;
        if (post == 1) busy_after = 32'(bus.busy);
      end
      if (bus.dut__xxx__finish) begin
        n_fin++;
        fin_cyc  = cyc;
        seen_fin = 1'b1;
      end
      if (bus.busy)              n_busy++;
      if (bus.H_read)            n_hread++;
      if (bus.H_iterate)         n_iter++;
      if (bus.H_update)          n_upd++;
      if (bus.dut__msg__enable)  q_addr.push_back(32'(bus.dut__msg__address));
      if (bus.W_load)            q_sel.push_back(32'(bus.W_byte_sel));
      if (bus.dut__hmem__enable) q_h.push_back(32'(bus.dut__hmem__address));
      if (bus.dut__kmem__enable) q_k.push_back(32'(bus.dut__kmem__address));
      if (bus.dut__dom__enable)  q_d.push_back(32'(bus.dut__dom__address));
      if (bus.H_read != prev_h)    lag_err++;
      if (bus.H_iterate != prev_k) lag_err++;
      if (prev_m && !bus.W_load)   lag_err++;
      if (bus.dut__msg__write || bus.dut__kmem__write || bus.dut__hmem__write ||
          (bus.dut__dom__enable != bus.dut__dom__write)) wr_err++;
      prev_h = bus.dut__hmem__enable;
      prev_k = bus.dut__kmem__enable;
      prev_m = bus.dut__msg__enable;
      bus.xxx__dut__go = poke_go && (cyc == k + 100);
    end
    bus.xxx__dut__go = 1'b0;

    check({p, "finish_cnt"}, n_fin, 1);
    check({p, "finish_cyc"}, fin_cyc, k + 17 + 136 * nblk);
    check({p, "busy_cyc"}, n_busy, 17 + 136 * nblk);
    check({p, "busy_after_done"}, busy_after, 0);
    check({p, "h_read_cnt"}, n_hread, 8);
    check({p, "h_iter_cnt"}, n_iter, total);
    check({p, "h_upd_cnt"}, n_upd, 8 * nblk);
    check({p, "lag_err"}, lag_err, 0);
    check({p, "write_err"}, wr_err, 0);

    check({p, "msg_cnt"}, q_addr.size(), lsat);
    for (int i = 0; i < q_addr.size() && i < int'(lsat); i++)
      check({p, $sformatf("msg_addr%0d", i)}, q_addr[i], i);
    check({p, "wload_cnt"}, q_sel.size(), total);
    for (int i = 0; i < q_sel.size() && i < int'(total); i++)
      check({p, $sformatf("wsel%0d", i)}, q_sel[i], pad_class(i, lsat, total));
    check({p, "hmem_cnt"}, q_h.size(), 8);
    for (int i = 0; i < q_h.size() && i < 8; i++)
      check({p, $sformatf("hmem_addr%0d", i)}, q_h[i], i);
    check({p, "kmem_cnt"}, q_k.size(), total);
    for (int i = 0; i < q_k.size() && i < int'(total); i++)
      check({p, $sformatf("kmem_addr%0d", i)}, q_k[i], i % 64);
    check({p, "dom_cnt"}, q_d.size(), 8);
    for (int i = 0; i < q_d.size() && i < 8; i++)
      check({p, $sformatf("dom_addr%0d", i)}, q_d[i], i);
  endtask

  initial begin
    reset_n                  = 1'b0;
    bus.xxx__dut__go         = 1'b0;
    bus.xxx__dut__msg_length = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", nonzero_outs(), 0);
    check("reset_busy", 32'(bus.busy), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", nonzero_outs(), 0);

    run_msg(3, 1'b0);
    run_msg(56, 1'b0);
    run_msg(0, 1'b0);
    run_msg(55, 1'b0);
    run_msg(64, 1'b0);
    run_msg(2, 1'b1);

    // Abort a run in the middle of the round phase
    @(negedge clk);
    bus.xxx__dut__go         = 1'b1;
    bus.xxx__dut__msg_length = 9'd10;
    @(negedge clk);
    bus.xxx__dut__go = 1'b0;
    for (int t = 0; t < 300 && !bus.dut__kmem__enable; t++) @(negedge clk);
    check("round_reached", 32'(bus.dut__kmem__enable), 1);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outs", nonzero_outs(), 0);
    check("async_reset_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_msg(5, 1'b0);

    run_msg(300, 1'b0);
    for (int r = 0; r < 5; r++) run_msg($urandom_range(0, 320), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
